// File: rtl/aes_sbox.sv
// AES byte substitution: forward or inverse S-box chosen per byte by inv.
// A single GF(2^8) inverter is shared between directions; the affine steps sit on either side of it.
module aes_sbox #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inv,
    input  logic [7:0] in,
    output logic [7:0] out
);

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and 0 maps to 0 without special casing.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) begin
            x240 = gf_mul(x240, x240);
        end
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] y);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] out_d;

    always_comb begin
        out_d = 8'h00;
        if (inv) begin
            out_d = gf_inv(inv_affine(in));
        end else begin
            out_d = fwd_affine(gf_inv(in));
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [7:0] out_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_q <= 8'h00;
                end else begin
                    out_q <= out_d;
                end
            end

            assign out = out_q;
        end else begin : g_comb
            assign out = out_d;
        end
    endgenerate

endmodule

// File: tb/tb_aes_sbox.sv
// Bench for aes_sbox: registered and combinational instances driven from one stimulus
// stream and compared against a brute-force GF(2^8) reference model.
module tb_aes_sbox;

    logic       clk;
    logic       reset;
    logic       inv;
    logic [7:0] in;
    logic [7:0] out;
    logic [7:0] out_c;

    int n_checks;
    int n_pass;
    logic [7:0] exp_q[$];
    int fwd_t[256];
    int inv_t[256];

    aes_sbox #(.OUT_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .inv(inv), .in(in), .out(out)
    );

    aes_sbox #(.OUT_REG(1'b0)) dut_c (
        .clk(clk), .reset(reset), .inv(inv), .in(in), .out(out_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: schoolbook GF arithmetic and brute-force inverse search
    function automatic int ref_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ a;
            a = a << 1;
            if (a & 'h100) a = a ^ 'h11B;
        end
        return p & 'hFF;
    endfunction

    function automatic int ref_inv(input int x);
        if (x == 0) return 0;
        for (int y = 1; y < 256; y++) begin
            if (ref_mul(x, y) == 1) return y;
        end
        return 0;
    endfunction

    function automatic int ref_fwd(input int x);
        int y, r, b;
        y = ref_inv(x);
        r = 0;
        for (int i = 0; i < 8; i++) begin
            b = ((y >> i) ^ (y >> ((i + 4) % 8)) ^ (y >> ((i + 5) % 8)) ^
                 (y >> ((i + 6) % 8)) ^ (y >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
            r = r | (b << i);
        end
        return r;
    endfunction

    function automatic int ref_bwd(input int x);
        int z, b;
        z = 0;
        for (int i = 0; i < 8; i++) begin
            b = ((x >> ((i + 2) % 8)) ^ (x >> ((i + 5) % 8)) ^
                 (x >> ((i + 7) % 8)) ^ ('h05 >> i)) & 1;
            z = z | (b << i);
        end
        return ref_inv(z);
    endfunction

    function automatic logic [7:0] model(input logic i, input logic [7:0] x);
        return i ? 8'(inv_t[x]) : 8'(fwd_t[x]);
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: apply one byte on the falling edge, score the registered result after the next rise
    task automatic step(input logic i, input logic [7:0] x, input string tag);
        logic [7:0] e;
        @(negedge clk);
        inv = i;
        in  = x;
        exp_q.push_back(model(i, x));
        #1;
        check_eq({tag, "_comb"}, out_c, model(i, x));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq(tag, out, e);
    endtask

    initial begin
        logic [7:0] fx;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        inv      = 1'b0;
        in       = 8'h53;
        for (int x = 0; x < 256; x++) begin
            fwd_t[x] = ref_fwd(x);
            inv_t[x] = ref_bwd(x);
        end

        // reset holds out at 0 across clock edges
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("reset_hold", out, 8'h00);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_release", out, 8'hED);

        // FIPS-197 spot values
        step(1'b0, 8'h00, "fwd_00"); check_eq("gold_fwd_00", out, 8'h63);
        step(1'b0, 8'h01, "fwd_01"); check_eq("gold_fwd_01", out, 8'h7C);
        step(1'b0, 8'h10, "fwd_10"); check_eq("gold_fwd_10", out, 8'hCA);
        step(1'b0, 8'h11, "fwd_11"); check_eq("gold_fwd_11", out, 8'h82);
        step(1'b0, 8'h53, "fwd_53"); check_eq("gold_fwd_53", out, 8'hED);
        step(1'b0, 8'hFF, "fwd_ff"); check_eq("gold_fwd_ff", out, 8'h16);
        step(1'b1, 8'h63, "inv_63"); check_eq("gold_inv_63", out, 8'h00);
        step(1'b1, 8'h00, "inv_00"); check_eq("gold_inv_00", out, 8'h52);
        step(1'b1, 8'h7C, "inv_7c"); check_eq("gold_inv_7c", out, 8'h01);
        step(1'b1, 8'hED, "inv_ed"); check_eq("gold_inv_ed", out, 8'h53);
        step(1'b1, 8'h16, "inv_16"); check_eq("gold_inv_16", out, 8'hFF);

        // exhaustive forward then inverse round trip
        for (int x = 0; x < 256; x++) begin
            step(1'b0, 8'(x), "exh_fwd");
            fx = out;
            step(1'b1, fx, "exh_inv");
            check_eq("round_trip", out, 8'(x));
        end

        // back-to-back stream with inv alternating every cycle
        for (int k = 0; k < 64; k++) begin
            step(1'(k % 2), 8'($urandom_range(0, 255)), "alt_stream");
        end

        // random direction and data
        for (int k = 0; k < 100; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rand");
        end

        // asynchronous reset between edges
        step(1'b0, 8'h53, "pre_async");
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset", out, 8'h00);
        check_eq("async_reset_comb", out_c, 8'hED);
        @(posedge clk);
        #1;
        check_eq("async_reset_hold", out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "post_async");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
